// File: rtl/alu_arb_pkg.sv
// Shared types and default sizes for the round-robin ALU arbiter and its picker.
// Purely declarative: no logic, no latency, no flow control.
package alu_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        OUT     = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } op_t;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Requester-side bundle of the shared ALU: per-requester req/operands/mode in, grant and tagged result out.
// Optional lock vector is present only when ARB_LOCK_EN is defined.
interface alu_rr_arbiter_if #(
    parameter int N_REQ = alu_arb_pkg::N_REQ_DEF,
    parameter int DW    = alu_arb_pkg::DW_DEF
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] in_a;
    logic [N_REQ*DW-1:0] in_b;
    logic [N_REQ-1:0]    mode;
    logic [N_REQ-1:0]    gnt;
    logic                out_valid;
    logic [2*DW-1:0]     out;
    logic [IW-1:0]       out_id;
`ifdef ARB_LOCK_EN
    logic [N_REQ-1:0]    lock;

    modport master (output req, in_a, in_b, mode, lock,
                    input  gnt, out_valid, out, out_id);
    modport slave  (input  req, in_a, in_b, mode, lock,
                    output gnt, out_valid, out, out_id);
`else
    modport master (output req, in_a, in_b, mode,
                    input  gnt, out_valid, out, out_id);
    modport slave  (input  req, in_a, in_b, mode,
                    output gnt, out_valid, out, out_id);
`endif

endinterface

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req after ptr (wrapping), as one-hot + index + any.
// Zero latency; no flow control of its own.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     any_o
);
    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = IW'((int'(ptr_i) + off) % N_REQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin share of one add/multiply unit: grant in IDLE, result strobe 2 cycles later, one result per 3 cycles.
// Requesters hold req until granted; gnt is held low while busy. ARB_LOCK_EN adds a per-requester grant lock.
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_rr_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N_REQ);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    op_t             op_q, op_d;
    logic [IW-1:0]   id_q, id_d;
    logic [2*DW-1:0] res_q, res_d;

    logic [N_REQ-1:0] cand_req;
    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

`ifdef ARB_LOCK_EN
    logic lock_q, lock_d;
    logic hold;

    // While locked, only the lock owner (always ptr) is eligible.
    assign hold     = lock_q && bus.lock[ptr_q];
    assign cand_req = hold ? (bus.req & (N_REQ'(1) << ptr_q)) : bus.req;
`else
    assign cand_req = bus.req;
`endif

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i (cand_req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        id_d          = id_q;
        res_d         = res_q;
        bus.gnt       = '0;
        bus.out_valid = (state_q == OUT);
        bus.out       = (state_q == OUT) ? res_q : '0;
        bus.out_id    = (state_q == OUT) ? id_q  : '0;
`ifdef ARB_LOCK_EN
        lock_d        = hold;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    bus.gnt = pick_gnt;
                    a_d     = bus.in_a[pick_idx*DW +: DW];
                    b_d     = bus.in_b[pick_idx*DW +: DW];
                    op_d    = op_t'(bus.mode[pick_idx]);
                    id_d    = pick_idx;
                    ptr_d   = pick_idx;
                    state_d = COMPUTE;
`ifdef ARB_LOCK_EN
                    lock_d  = bus.lock[pick_idx];
`endif
                end
            end
            COMPUTE: begin
                // Zero-extended operands: the full product always fits in 2*DW.
                if (op_q == OP_MUL)
                    res_d = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
                else
                    res_d = {{DW{1'b0}}, a_q} + {{DW{1'b0}}, b_q};
                state_d = OUT;
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            id_q    <= '0;
            res_q   <= '0;
`ifdef ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            res_q   <= res_d;
`ifdef ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

endmodule
